// File: rtl/stats_reader_pkg.sv
// Shared constants and state encoding for the stats FIFO reader.
// Build option STATS_READER_HEADER_EN prefixes each record with one header beat.
package stats_reader_pkg;

    localparam int unsigned DEF_RECORD_WIDTH = 448;
    localparam int unsigned DEF_WORD_WIDTH   = 32;
    localparam int unsigned WORDS            = DEF_RECORD_WIDTH / DEF_WORD_WIDTH;
    localparam int unsigned IDX_W            = $clog2(WORDS + 1);

    localparam int unsigned HDR_SEQ_W = 16;
    localparam int unsigned HDR_CNT_W = 16;

`ifdef STATS_READER_HEADER_EN
    localparam int unsigned HDR_BEATS = 1;
`else
    localparam int unsigned HDR_BEATS = 0;
`endif

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_POP  = 2'd1;
    localparam state_t S_WAIT = 2'd2;
    localparam state_t S_SEND = 2'd3;

endpackage

// File: rtl/stats_word_shifter.sv
// Record holding register: parallel load of a full record, shifts right one word per advance.
// The low word is the word currently presented on the stream.
module stats_word_shifter
    import stats_reader_pkg::*;
#(
    parameter int unsigned RECORD_WIDTH = DEF_RECORD_WIDTH,
    parameter int unsigned WORD_WIDTH   = DEF_WORD_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_load,
    input  logic [RECORD_WIDTH-1:0] i_data,
    input  logic                    i_advance,
    output logic [WORD_WIDTH-1:0]   o_word
);

    logic [RECORD_WIDTH-1:0] r_shift;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_advance) begin
            r_shift <= r_shift >> WORD_WIDTH;
        end
    end

    assign o_word = r_shift[WORD_WIDTH-1:0];

endmodule

// File: rtl/stats_fifo_reader.sv
// Drains 448-bit stats records from a standard-mode FIFO onto an AXI-Stream master, LSB word first.
// Build option STATS_READER_HEADER_EN adds a {sequence, word count} header beat per record.
module stats_fifo_reader
    import stats_reader_pkg::*;
#(
    parameter int unsigned RECORD_WIDTH = DEF_RECORD_WIDTH,
    parameter int unsigned WORD_WIDTH   = DEF_WORD_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic                    i_fifo_empty,
    output logic                    o_fifo_rd_en,
    input  logic                    i_fifo_valid,
    input  logic [RECORD_WIDTH-1:0] i_fifo_dout,
    output logic [WORD_WIDTH-1:0]   o_m_axis_tdata,
    output logic                    o_m_axis_tvalid,
    input  logic                    i_m_axis_tready,
    output logic                    o_m_axis_tlast,
    output logic                    o_busy,
    output logic [31:0]             o_records_sent
);

    localparam int unsigned LP_WORDS = RECORD_WIDTH / WORD_WIDTH;
    localparam int unsigned LP_IDX_W = $clog2(LP_WORDS + 1);
    localparam int unsigned LP_BEATS = LP_WORDS + HDR_BEATS;
    localparam logic [LP_IDX_W-1:0] LP_LAST_IDX = LP_IDX_W'(LP_BEATS - 1);

    state_t                r_state;
    state_t                w_state_d;
    logic [LP_IDX_W-1:0]   r_idx;
    logic [31:0]           r_records;
    logic                  w_can_pop;
    logic                  w_beat;
    logic                  w_last;
    logic                  w_load;
    logic                  w_rd_en;
    logic                  w_advance;
    logic [WORD_WIDTH-1:0] w_word;

    assign w_can_pop = i_enable && !i_fifo_empty;
    assign w_beat    = (r_state == S_SEND) && i_m_axis_tready;
    assign w_last    = (r_idx == LP_LAST_IDX);

    // The strobe is issued from IDLE or on the accepted last beat, so it never overlaps POP/WAIT.
    always_comb begin
        w_state_d = r_state;
        w_rd_en   = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_pop) begin
                    w_rd_en   = 1'b1;
                    w_state_d = S_POP;
                end
            end
            S_POP: w_state_d = S_WAIT;
            S_WAIT: begin
                if (i_fifo_valid) begin
                    w_load    = 1'b1;
                    w_state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (w_beat && w_last) begin
                    if (w_can_pop) begin
                        w_rd_en   = 1'b1;
                        w_state_d = S_POP;
                    end else begin
                        w_state_d = S_IDLE;
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_records <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_load) begin
                r_idx <= '0;
            end else if (w_beat) begin
                r_idx <= w_last ? '0 : r_idx + LP_IDX_W'(1);
            end
            if (w_beat && w_last) begin
                r_records <= r_records + 32'd1;
            end
        end
    end

`ifdef STATS_READER_HEADER_EN
    localparam logic [HDR_CNT_W-1:0] LP_HDR_CNT = HDR_CNT_W'(LP_WORDS);

    logic [HDR_SEQ_W-1:0]  r_seq;
    logic                  w_hdr_beat;
    logic [WORD_WIDTH-1:0] w_header;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seq <= '0;
        end else if (w_beat && w_last) begin
            r_seq <= r_seq + HDR_SEQ_W'(1);
        end
    end

    // Beat 0 is the header; the shifter only advances on data beats.
    assign w_hdr_beat     = (r_state == S_SEND) && (r_idx == '0);
    assign w_header       = WORD_WIDTH'({r_seq, LP_HDR_CNT});
    assign w_advance      = w_beat && !w_hdr_beat;
    assign o_m_axis_tdata = w_hdr_beat ? w_header : w_word;
`else
    assign w_advance      = w_beat;
    assign o_m_axis_tdata = w_word;
`endif

    stats_word_shifter #(
        .RECORD_WIDTH (RECORD_WIDTH),
        .WORD_WIDTH   (WORD_WIDTH)
    ) u_shifter (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (w_load),
        .i_data    (i_fifo_dout),
        .i_advance (w_advance),
        .o_word    (w_word)
    );

    assign o_fifo_rd_en    = w_rd_en;
    assign o_m_axis_tvalid = (r_state == S_SEND);
    assign o_m_axis_tlast  = (r_state == S_SEND) && w_last;
    assign o_busy          = (r_state != S_IDLE);
    assign o_records_sent  = r_records;

endmodule

// File: tb/tb_stats_fifo_reader.sv
// Directed bench for stats_fifo_reader: FIFO model, beat monitor, table-driven backpressure vectors.
module tb_stats_fifo_reader;
    import stats_reader_pkg::*;

    localparam int HDR   = int'(HDR_BEATS);
    localparam int NW    = int'(WORDS);
    localparam int BEATS = NW + HDR;

    typedef struct {
        logic        tready;
        logic        exp_tvalid;
        logic [31:0] exp_tdata;
        logic        exp_tlast;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic         fifo_valid = 1'b0;
    logic [447:0] fifo_dout = '0;
    logic [31:0]  tdata;
    logic         tvalid;
    logic         tready = 1'b0;
    logic         tlast;
    logic         busy;
    logic [31:0]  records_sent;

    stats_fifo_reader u_dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_enable        (enable),
        .i_fifo_empty    (fifo_empty),
        .o_fifo_rd_en    (fifo_rd_en),
        .i_fifo_valid    (fifo_valid),
        .i_fifo_dout     (fifo_dout),
        .o_m_axis_tdata  (tdata),
        .o_m_axis_tvalid (tvalid),
        .i_m_axis_tready (tready),
        .o_m_axis_tlast  (tlast),
        .o_busy          (busy),
        .o_records_sent  (records_sent)
    );

    always #5 clk = ~clk;

    // FIFO model: read strobe is registered, data_valid follows one cycle later.
    logic [447:0] fifo_mem [8];
    logic [447:0] pend = '0;
    logic         rd_q = 1'b0;
    int           wr_ptr = 0;
    int           rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        rd_q       <= fifo_rd_en;
        fifo_valid <= rd_q;
        fifo_dout  <= pend;
        if (fifo_rd_en && !fifo_empty) begin
            pend   <= fifo_mem[rd_ptr % 8];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Monitor: accepted beats, strobe cycles, hold-stability and illegal strobe counts.
    logic [31:0] beat_q [$];
    logic        last_q [$];
    int          beat_cyc [$];
    int          rd_cyc [$];
    int          cyc = 0;
    int          hold_err = 0;
    int          bad_rd = 0;
    logic        p_hold = 1'b0;
    logic [31:0] p_data = '0;
    logic        p_last = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (fifo_rd_en) rd_cyc.push_back(cyc);
            if (fifo_rd_en && fifo_empty) bad_rd <= bad_rd + 1;
            if (tvalid && tready) begin
                beat_q.push_back(tdata);
                last_q.push_back(tlast);
                beat_cyc.push_back(cyc);
            end
            if (p_hold && !(tvalid && tdata == p_data && tlast == p_last)) hold_err <= hold_err + 1;
            p_hold <= tvalid && !tready;
            p_data <= tdata;
            p_last <= tlast;
        end else begin
            p_hold <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [447:0] make_rec(input logic [31:0] base);
        logic [447:0] r;
        r = '0;
        for (int i = 0; i < NW; i++) r[i*32 +: 32] = base + 32'(i);
        return r;
    endfunction

    function automatic logic [31:0] exp_beat(input logic [31:0] base, input int seq, input int k);
        logic [15:0] s;
        s = seq[15:0];
        if (HDR == 1 && k == 0) return {s, 16'(NW)};
        return base + 32'(k - HDR);
    endfunction

    task automatic push(input logic [31:0] base);
        fifo_mem[wr_ptr % 8] = make_rec(base);
        wr_ptr++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_beats(input int target, input string name);
        int n;
        n = 0;
        while (beat_q.size() < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(beat_q.size() >= target), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   b;
        int   r;
        int   seq;
        int   k;
        int   n;
        vec_t tab [$];
        logic pat [4];

        seq = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_records", records_sent, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        rst_n = 1'b1;
        idle(2);

        // Single record, tready held high
        tready = 1'b1;
        b = beat_q.size();
        r = rd_cyc.size();
        push(32'h0);
        enable = 1'b1;
        wait_beats(b + BEATS, "single_done");
        idle(3);
        for (int j = 0; j < BEATS; j++) begin
            check($sformatf("single_data%0d", j), beat_q[b+j], exp_beat(32'h0, seq, j));
            check($sformatf("single_last%0d", j), last_q[b+j], 64'(j == BEATS - 1));
        end
        check("single_records", records_sent, 1);
        check("single_rd_pulses", rd_cyc.size() - r, 1);
        check("single_latency", beat_cyc[b] - rd_cyc[r], 3);
        check("single_busy_after", busy, 0);
        seq++;

        // Backpressure: tready pattern 1,0,0,1 per cycle, vectors built up front
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        k = 0;
        n = 0;
        while (k < BEATS) begin
            tab.push_back('{tready: pat[n % 4], exp_tvalid: 1'b1,
                            exp_tdata: exp_beat(32'hA000_0000, seq, k),
                            exp_tlast: (k == BEATS - 1)});
            if (pat[n % 4]) k++;
            n++;
        end
        tready = 1'b0;
        b = beat_q.size();
        push(32'hA000_0000);
        n = 0;
        while (!tvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_start", tvalid, 1);
        for (int i = 0; i < tab.size(); i++) begin
            check($sformatf("bp_tvalid%0d", i), tvalid, tab[i].exp_tvalid);
            check($sformatf("bp_tdata%0d", i), tdata, tab[i].exp_tdata);
            check($sformatf("bp_tlast%0d", i), tlast, tab[i].exp_tlast);
            tready = tab[i].tready;
            @(negedge clk);
        end
        check("bp_tvalid_after", tvalid, 0);
        check("bp_beats", beat_q.size() - b, BEATS);
        check("bp_records", records_sent, 2);
        tready = 1'b1;
        seq++;
        idle(2);

        // Back-to-back: three queued records
        b = beat_q.size();
        r = rd_cyc.size();
        push(32'h100);
        push(32'h200);
        push(32'h300);
        wait_beats(b + 3 * BEATS, "b2b_done");
        idle(4);
        check("b2b_rd_pulses", rd_cyc.size() - r, 3);
        check("b2b_gap1", beat_cyc[b+BEATS] - beat_cyc[b+BEATS-1], 3);
        check("b2b_gap2", beat_cyc[b+2*BEATS] - beat_cyc[b+2*BEATS-1], 3);
        check("b2b_rec2_word0", beat_q[b+BEATS+HDR], 32'h200);
        check("b2b_rec3_last", beat_q[b+3*BEATS-1], 32'h300 + 32'(NW - 1));
        check("b2b_records", records_sent, 5);
        check("b2b_beats", beat_q.size() - b, 3 * BEATS);
        seq += 3;

        // enable dropped while beat 5 of the first record is on the bus
        b = beat_q.size();
        r = rd_cyc.size();
        push(32'h400);
        push(32'h500);
        wait_beats(b + 4, "en_drop_reach5");
        enable = 1'b0;
        wait_beats(b + BEATS, "en_drop_rec_done");
        idle(10);
        check("en_drop_records", records_sent, 6);
        check("en_drop_rd_pulses", rd_cyc.size() - r, 1);
        check("en_drop_busy", busy, 0);
        check("en_drop_beats", beat_q.size() - b, BEATS);
        check("en_drop_fifo_left", wr_ptr - rd_ptr, 1);
        check("en_drop_last", last_q[b+BEATS-1], 1);
        seq++;
        enable = 1'b1;
        wait_beats(b + 2 * BEATS, "drain_done");
        idle(3);
        check("drain_word0", beat_q[b+BEATS+HDR], 32'h500);
        check("drain_records", records_sent, 7);
        seq++;

        // Reset while beat 7 is presented
        b = beat_q.size();
        push(32'h600);
        wait_beats(b + 6, "rst_reach7");
        rst_n = 1'b0;
        #1;
        check("midrst_tvalid", tvalid, 0);
        check("midrst_tlast", tlast, 0);
        check("midrst_tdata", tdata, 0);
        check("midrst_busy", busy, 0);
        check("midrst_records", records_sent, 0);
        idle(2);
        rst_n = 1'b1;
        seq = 0;
        idle(20);
        check("postrst_beats", beat_q.size() - b, 6);
        check("postrst_tvalid", tvalid, 0);
        check("postrst_busy", busy, 0);
        check("postrst_records", records_sent, 0);

`ifdef STATS_READER_HEADER_EN
        // Header sequence numbering restarts after reset
        b = beat_q.size();
        push(32'h700);
        push(32'h800);
        wait_beats(b + 2 * BEATS, "hdr_done");
        idle(3);
        check("hdr0", beat_q[b], 32'h0000_000E);
        check("hdr1", beat_q[b+BEATS], 32'h0001_000E);
        check("hdr0_not_last", last_q[b], 0);
        check("hdr_rec0_data0", beat_q[b+1], 32'h700);
        check("hdr_rec0_last", last_q[b+14], 1);
        check("hdr_rec1_last", last_q[b+29], 1);
        check("hdr_records", records_sent, 2);
`endif

        check("hold_stable", hold_err, 0);
        check("no_rd_when_empty", bad_rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
